// File: rtl/issue_scoreboard_pkg.sv
// Shared types for the issue scoreboard: control states, destination-file
// encodings, the per-slot view and the register-id helper.
package issue_scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALT      = 2'd3
  } sb_state_t;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  // Slot view is sized for the widest supported latency field (LAT_W <= 8).
  localparam int REM_W = 8;

  typedef struct packed {
    logic             valid;
    logic [5:0]       dest;
    logic [REM_W-1:0] rem;
  } slot_t;

  function automatic logic [5:0] regid(input logic fpr, input logic [4:0] idx);
    return {fpr, idx};
  endfunction

endpackage

// File: rtl/issue_scoreboard_slot.sv
// One in-flight operation slot: loaded with remaining latency, counts down,
// and expires (write-back) in the cycle its counter reads zero.
module sb_slot
  import issue_scoreboard_pkg::*;
#(
  parameter int LAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [5:0]       load_dest,
  input  logic [LAT_W-1:0] load_rem,
  output slot_t            slot,
  output logic             expire
);

  logic             valid_q;
  logic [5:0]       dest_q;
  logic [LAT_W-1:0] rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      dest_q  <= 6'd0;
      rem_q   <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      dest_q  <= load_dest;
      rem_q   <= load_rem;
    end else if (valid_q) begin
      // The expiring cycle still counts as valid so the dest stays pending.
      if (rem_q == '0) valid_q <= 1'b0;
      else             rem_q   <= rem_q - 1'b1;
    end
  end

  assign expire = valid_q && (rem_q == '0);
  assign slot   = {valid_q, dest_q, REM_W'(rem_q)};

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks pending destinations in ENTRIES latency
// slots, blocks RAW/WAW hazards and write-port collisions, sequences ctrl/halt.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int LAT_W   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             dec_valid,
  input  logic [5:0]       dec_rs,
  input  logic [5:0]       dec_rt,
  input  logic [4:0]       dec_rd,
  input  logic [1:0]       dec_rw,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             dec_ctrl,
  input  logic             dec_stop,
  input  logic             br_resolved,
  output logic             issue,
  output logic             stall,
  output logic             wb_valid,
  output logic [5:0]       wb_dest,
  output logic             halted,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: the decoder holds dec_* stable while dec_valid=1; the
  // instruction is consumed in exactly the cycle issue=1, otherwise stall=1.

  sb_state_t          state;
  slot_t              slots [ENTRIES];
  logic [ENTRIES-1:0] slot_valid;
  logic [ENTRIES-1:0] slot_expire;
  logic [ENTRIES-1:0] alloc_oh;
  logic [ENTRIES-1:0] slot_load;
  logic [63:0]        pending;
  logic [LAT_W-1:0]   lat_eff;
  logic [LAT_W-1:0]   load_rem;
  logic [5:0]         dest_id;
  logic               tracked;
  logic               rs_pend, rt_pend, waw, collide, found;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
    sb_slot #(.LAT_W(LAT_W)) u_slot (
      .clk       (clk),
      .rst       (rstn),
      .load      (slot_load[i]),
      .load_dest (dest_id),
      .load_rem  (load_rem),
      .slot      (slots[i]),
      .expire    (slot_expire[i])
    );
    assign slot_valid[i] = slots[i].valid;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (slots[i].valid) pending[slots[i].dest] = 1'b1;
  end

  always_comb begin
    lat_eff  = (dec_lat == '0) ? LAT_W'(1) : dec_lat;
    load_rem = lat_eff - LAT_W'(1);
    dest_id  = regid(dec_rw == RW_FPR, dec_rd);
    tracked  = (dec_rw == RW_GPR || dec_rw == RW_FPR) && (dest_id != 6'd0);
    rs_pend  = (dec_rs != 6'd0) && pending[dec_rs];
    rt_pend  = (dec_rt != 6'd0) && pending[dec_rt];
    waw      = tracked && pending[dest_id];
    collide  = 1'b0;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      // A slot with rem == L would share our write-back cycle.
      if (slots[i].valid && slots[i].rem == REM_W'(lat_eff)) collide = 1'b1;
      if (!slots[i].valid && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
    issue     = (state == ST_RUN) && dec_valid && !rs_pend && !rt_pend &&
                !waw && found && !collide;
    stall     = dec_valid && !issue;
    slot_load = (issue && tracked) ? alloc_oh : '0;
  end

  always_comb begin
    wb_valid = |slot_expire;
    wb_dest  = 6'd0;
    for (int i = 0; i < ENTRIES; i++)
      if (slot_expire[i]) wb_dest = wb_dest | slots[i].dest;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (issue && dec_stop)      state <= ST_DRAIN;
          else if (issue && dec_ctrl) state <= ST_CTRL_WAIT;
        end
        ST_CTRL_WAIT: if (br_resolved) state <= ST_RUN;
        // Halt once nothing survives this edge, i.e. right after the last write-back.
        ST_DRAIN:     if ((slot_valid & ~slot_expire) == '0) state <= ST_HALT;
        default:      state <= ST_HALT;
      endcase
    end
  end

  assign halted    = (state == ST_HALT);
  assign busy      = |slot_valid;
  assign dbg_state = state;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scenario bench for issue_scoreboard: per-feature tasks plus a write-back
// scoreboard keyed by expected cycle and destination.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  localparam int ENTRIES = 4;
  localparam int LAT_W   = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             dec_valid, dec_ctrl, dec_stop, br_resolved;
  logic [5:0]       dec_rs, dec_rt;
  logic [4:0]       dec_rd;
  logic [1:0]       dec_rw;
  logic [LAT_W-1:0] dec_lat;
  logic             issue, stall, wb_valid, halted, busy;
  logic [5:0]       wb_dest;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [37:0] exp_q[$];
  logic [37:0] mon_exp;

  issue_scoreboard #(.ENTRIES(ENTRIES), .LAT_W(LAT_W)) dut (
    .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rd(dec_rd), .dec_rw(dec_rw), .dec_lat(dec_lat), .dec_ctrl(dec_ctrl),
    .dec_stop(dec_stop), .br_resolved(br_resolved), .issue(issue), .stall(stall),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .halted(halted), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-back scoreboard: every pulse must match the head {cycle, dest}
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got dest=%h at cyc %0d, required no write-back", wb_dest, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({32'(cyc), wb_dest} !== mon_exp) begin
          errors++;
          $display("FAIL wb_match: got cyc %0d dest=%h, required cyc %0d dest=%h",
                   cyc, wb_dest, mon_exp[37:6], mon_exp[5:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dec_valid = 1'b0; dec_rs = 6'd0; dec_rt = 6'd0; dec_rd = 5'd0;
    dec_rw = RW_NONE; dec_lat = '0; dec_ctrl = 1'b0; dec_stop = 1'b0;
  endtask

  task automatic op(input logic [5:0] rs, input logic [5:0] rt, input logic [1:0] rw,
                    input logic [4:0] rd, input logic [LAT_W-1:0] lat);
    dec_valid = 1'b1; dec_rs = rs; dec_rt = rt; dec_rw = rw; dec_rd = rd;
    dec_lat = lat; dec_ctrl = 1'b0; dec_stop = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    idle();
    @(negedge clk);
    while (busy !== 1'b0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_missing: %0d write-backs outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1; br_resolved = 1'b0; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (issue !== 1'b0)    begin errors++; $display("FAIL reset_issue: got %b required 0", issue); end
    if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b required 0", wb_valid); end
    if (wb_dest !== 6'd0)  begin errors++; $display("FAIL reset_wb_dest: got %h required 00", wb_dest); end
    if (halted !== 1'b0)   begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    rstn = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    int t0;
    t0 = cyc;
    op(6'd0, 6'd0, RW_GPR, 5'd5, 5'd6);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 6), 6'h05});
    tick();
    for (int k = 1; k <= 6; k++) begin
      op(6'd5, 6'd0, RW_GPR, 5'd6, 5'd2);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || issue !== 1'b0) begin
        errors++; $display("FAIL raw_stall: T=%0d stall=%b issue=%b required stall=1 issue=0", k, stall, issue);
      end
      tick();
    end
    op(6'd5, 6'd0, RW_GPR, 5'd6, 5'd2);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL raw_dep_issue: T=7 got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 9), 6'h06});
    tick();
    wait_idle();
  endtask

  task automatic test_collision();
    int t0;
    t0 = cyc;
    op(6'd0, 6'd0, RW_FPR, 5'd3, 5'd16);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL col_fpu_issue: got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 16), 6'h23});
    tick();
    idle();
    repeat (9) tick();
    op(6'd0, 6'd0, RW_GPR, 5'd4, 5'd6);
    @(negedge clk);
    checks++;
    if (issue !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL col_reject: issue=%b stall=%b required issue=0 stall=1", issue, stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL col_retry_issue: got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 17), 6'h04});
    tick();
    wait_idle();
  endtask

  task automatic test_full();
    int t0;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      op(6'd0, 6'd0, RW_GPR, 5'(10 + i), 5'd16);
      @(negedge clk);
      checks++;
      if (issue !== 1'b1) begin errors++; $display("FAIL full_fill_issue: op %0d got %b required 1", i, issue); end
      exp_q.push_back({32'(t0 + i + 16), regid(1'b0, 5'(10 + i))});
      tick();
    end
    for (int k = 4; k <= 16; k++) begin
      op(6'd0, 6'd0, RW_GPR, 5'd14, 5'd16);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL full_stall: T=%0d stall=%b busy=%b required 1 1", k, stall, busy);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL full_fifth_issue: T=17 got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 33), 6'h0e});
    tick();
    wait_idle();
  endtask

  task automatic test_gpr0();
    int t0;
    t0 = cyc;
    op(6'd0, 6'd0, RW_GPR, 5'd0, 5'd3);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL gpr0_write_issue: got %b required 1", issue); end
    tick();
    op(6'd0, 6'd0, RW_GPR, 5'd7, 5'd1);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL gpr0_read: issue=%b busy=%b required issue=1 busy=0", issue, busy);
    end
    exp_q.push_back({32'(t0 + 2), 6'h07});
    tick();
    op(6'd0, 6'd0, 2'b11, 5'd9, 5'd2);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL rw11_issue: got %b required 1", issue); end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL untracked_busy: got %b required 0", busy); end
    tick();
    wait_idle();
  endtask

  task automatic test_branch();
    op(6'd0, 6'd0, RW_NONE, 5'd0, 5'd1);
    br_resolved = 1'b1;
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL br_run_pulse: issue=%b required 1", issue); end
    tick();
    br_resolved = 1'b0;
    op(6'd0, 6'd0, RW_NONE, 5'd0, 5'd1);
    dec_ctrl = 1'b1;
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL br_issue: got %b required 1", issue); end
    tick();
    for (int k = 1; k <= 5; k++) begin
      op(6'd0, 6'd0, RW_NONE, 5'd0, 5'd1);
      br_resolved = (k == 5);
      @(negedge clk);
      checks++;
      if (issue !== 1'b0 || dbg_state !== ST_CTRL_WAIT) begin
        errors++; $display("FAIL br_wait: T=%0d issue=%b state=%0d required issue=0 state=1", k, issue, dbg_state);
      end
      tick();
    end
    br_resolved = 1'b0;
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL br_resume: T=6 got %b required 1", issue); end
    tick();
    idle();
  endtask

  task automatic test_stop_drain();
    int t0;
    t0 = cyc;
    op(6'd0, 6'd0, RW_GPR, 5'd8, 5'd4);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL stop_opa_issue: got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 4), 6'h08});
    tick();
    op(6'd0, 6'd0, RW_GPR, 5'd9, 5'd5);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL stop_opb_issue: got %b required 1", issue); end
    exp_q.push_back({32'(t0 + 6), 6'h09});
    tick();
    op(6'd0, 6'd0, RW_NONE, 5'd0, 5'd1);
    dec_stop = 1'b1;
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL stop_issue: got %b required 1", issue); end
    tick();
    idle();
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      checks++;
      if (halted !== (k == 7) || dbg_state !== ((k == 7) ? ST_HALT : ST_DRAIN)) begin
        errors++; $display("FAIL drain_halted: T=%0d halted=%b state=%0d required halted=%b", k, halted, dbg_state, k == 7);
      end
      tick();
    end
    op(6'd0, 6'd0, RW_GPR, 5'd1, 5'd1);
    @(negedge clk);
    checks++;
    if (issue !== 1'b0 || stall !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_block: issue=%b stall=%b busy=%b required 0 1 0", issue, stall, busy);
    end
    idle();
    rstn = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: halted=%b required 0", halted); end
    tick();
    rstn = 1'b0;
    tick();
    // Reset mid-drain with a long-latency op in flight
    op(6'd0, 6'd0, RW_GPR, 5'd15, 5'd20);
    @(negedge clk);
    checks++;
    if (issue !== 1'b1) begin errors++; $display("FAIL mid_op_issue: got %b required 1", issue); end
    tick();
    op(6'd0, 6'd0, RW_NONE, 5'd0, 5'd1);
    dec_stop = 1'b1;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (dbg_state !== ST_DRAIN || busy !== 1'b1) begin
      errors++; $display("FAIL mid_drain: state=%0d busy=%b required 2 1", dbg_state, busy);
    end
    tick();
    rstn = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++; $display("FAIL mid_reset: halted=%b busy=%b wb_valid=%b state=%0d required 0 0 0 0",
                         halted, busy, wb_valid, dbg_state);
    end
    tick();
    rstn = 1'b0;
    repeat (25) tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL post_reset: busy=%b pending_wb=%0d required 0 0", busy, exp_q.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_collision();
    test_full();
    test_gpr0();
    test_branch();
    test_stop_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
